// File: rtl/irig_pkg.sv
// Shared symbol codes, FSM encoding and pulse-width classifier for the IRIG-B decode path.
package irig_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StLost
  } irig_state_e;

  localparam logic [2:0] SYM_ZERO = 3'b001;
  localparam logic [2:0] SYM_ONE  = 3'b011;
  localparam logic [2:0] SYM_MARK = 3'b111;
  localparam logic [2:0] SYM_ERR  = 3'b000;

  localparam int unsigned IRIG_BITS_PER_FRAME = 100;

  // Thresholds sit halfway between the nominal 2/5/8 ms widths; ms_ticks is a parameter so
  // every division folds to a constant.
  function automatic logic [2:0] irig_classify(input int unsigned width,
                                               input int unsigned ms_ticks);
    if (width < ms_ticks) begin
      return SYM_ERR;
    end else if (width < (7 * ms_ticks) / 2) begin
      return SYM_ZERO;
    end else if (width < (13 * ms_ticks) / 2) begin
      return SYM_ONE;
    end else if (width < (19 * ms_ticks) / 2) begin
      return SYM_MARK;
    end
    return SYM_ERR;
  endfunction

endpackage

// File: rtl/irig_in_filter.sv
// Synchroniser and ce-qualified edge detector for the raw IRIG-B level.
// Optional glitch filter built only when IRIG_GLITCH_FILT_EN is defined.
module irig_in_filter #(
  parameter int unsigned GLITCH_TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic irig_i,
  output logic level_o,
  output logic level_valid_o,
  output logic rise_o,
  output logic fall_o
);

  if (GLITCH_TICKS == 0) begin : g_bad_glitch
    $error("GLITCH_TICKS must be at least 1");
  end

  logic [1:0] sync_q;
  logic [1:0] primed_q;
  logic       level_q;
  logic       sample;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b00;
      primed_q <= 2'b00;
    end else begin
      sync_q   <= {sync_q[0], irig_i};
      primed_q <= {primed_q[0], 1'b1};
    end
  end

`ifdef IRIG_GLITCH_FILT_EN
  localparam int unsigned GcntW = $clog2(GLITCH_TICKS + 1);

  logic [GcntW-1:0] gcnt_q, gcnt_d;
  logic             accept;

  assign accept = ce_i && (sync_q[1] != level_q) && (gcnt_q == GcntW'(GLITCH_TICKS - 1));
  assign sample = accept ? sync_q[1] : level_q;

  always_comb begin
    gcnt_d = gcnt_q;
    if (ce_i) begin
      if ((sync_q[1] == level_q) || accept) begin
        gcnt_d = '0;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  // Not trustworthy until the filter agrees with the raw level, else a high present at
  // reset release would look like a low.
  assign level_valid_o = primed_q[1] && (sync_q[1] == level_q);
`else
  assign sample        = sync_q[1];
  assign level_valid_o = primed_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else if (ce_i) begin
      level_q <= sample;
    end
  end

  assign level_o = sample;
  assign rise_o  = ce_i && sample && !level_q;
  assign fall_o  = ce_i && !sample && level_q;

endmodule

// File: rtl/irig_symbol_decoder.sv
// IRIG-B symbol decoder: measures high pulses, classifies them, tracks frame reference and index.
// Define IRIG_GLITCH_FILT_EN to build the input glitch filter.
module irig_symbol_decoder
  import irig_pkg::*;
#(
  parameter int unsigned MS_TICKS     = 100,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned GLITCH_TICKS = 4
) (
  input  logic       clk_i,
  input  logic       hrd_rst_ni,
  input  logic       ce_i,
  input  logic       irig_in_i,
  output logic [2:0] irig_data_o,
  output logic       en_o,
  output logic       frame_sync_o,
  output logic [7:0] ind_o,
  output logic       ind_valid_o,
  output logic       sig_lost_o
);

  if (12 * MS_TICKS >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for 12 ms timeout");
  end

  localparam logic [CNT_W-1:0] TimeoutTicks = CNT_W'(12 * MS_TICKS);
  localparam logic [7:0]       LastInd      = 8'(IRIG_BITS_PER_FRAME - 1);

  logic level, level_valid, rise, fall;

  irig_in_filter #(
    .GLITCH_TICKS(GLITCH_TICKS)
  ) u_in_filter (
    .clk_i        (clk_i),
    .rst_ni       (hrd_rst_ni),
    .ce_i         (ce_i),
    .irig_i       (irig_in_i),
    .level_o      (level),
    .level_valid_o(level_valid),
    .rise_o       (rise),
    .fall_o       (fall)
  );

  irig_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       data_q, data_d, sym;
  logic [7:0]       ind_q, ind_d;
  logic             en_q, en_d, fs_q, fs_d, iv_q, iv_d, lost_q, lost_d, mark_q, mark_d;
  logic             timeout;

  assign cnt_inc = cnt_q + 1'b1;
  // >= so a fall just before the limit still times out from LOW.
  assign timeout = (cnt_inc >= TimeoutTicks);
  assign sym     = irig_classify(32'(cnt_q), MS_TICKS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ind_d   = ind_q;
    iv_d    = iv_q;
    lost_d  = lost_q;
    mark_d  = mark_q;
    en_d    = 1'b0;
    fs_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ce_i && level_valid && !level) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CNT_W'(1);
        end else if (ce_i) begin
          if (timeout) begin
            state_d = StLost;
            cnt_d   = '0;
            lost_d  = 1'b1;
            iv_d    = 1'b0;
            mark_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          cnt_d   = cnt_inc;
          en_d    = 1'b1;
          data_d  = sym;
          mark_d  = (sym == SYM_MARK);
          if (sym != SYM_ERR) begin
            lost_d = 1'b0;
          end
          if ((sym == SYM_MARK) && mark_q) begin
            fs_d  = 1'b1;
            ind_d = '0;
            iv_d  = 1'b1;
          end else begin
            ind_d = (ind_q == LastInd) ? '0 : ind_q + 1'b1;
          end
        end else if (ce_i) begin
          if (timeout) begin
            state_d = StLost;
            cnt_d   = '0;
            lost_d  = 1'b1;
            iv_d    = 1'b0;
            mark_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StLost: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge hrd_rst_ni) begin
    if (!hrd_rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= SYM_ERR;
      ind_q   <= '0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      iv_q    <= 1'b0;
      lost_q  <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ind_q   <= ind_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      iv_q    <= iv_d;
      lost_q  <= lost_d;
      mark_q  <= mark_d;
    end
  end

  assign irig_data_o  = data_q;
  assign en_o         = en_q;
  assign frame_sync_o = fs_q;
  assign ind_o        = ind_q;
  assign ind_valid_o  = iv_q;
  assign sig_lost_o   = lost_q;

endmodule
